// File: rtl/trans4_rr_sched.sv
// Round-robin scheduler granting the 4-channel selector datapath to one of four requesters.
// Define TRANS4_FIXED_PRIO_EN to replace round-robin with fixed priority (0 highest).
module trans4_rr_sched #(
    parameter int HOLD  = 4,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       base;
    logic [1:0]       win;
    logic [1:0]       idx;
    logic             take;

`ifdef TRANS4_FIXED_PRIO_EN
    assign base = 2'd3;
`else
    logic [1:0] last;
    assign base = last;
`endif

    // Scan from base+4 down to base+1 so the nearest requester after base wins.
    always_comb begin
        win = base;
        idx = '0;
        for (int unsigned i = 4; i >= 1; i--) begin
            idx = base + 2'(i);
            if (req[idx]) win = idx;
        end
    end

    // A new pick happens every edge in IDLE and at slice end in GRANT.
    always_comb begin
        take = 1'b0;
        if (state == IDLE) take = 1'b1;
        else if ((cnt == '0) || !req[sel]) take = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
`ifndef TRANS4_FIXED_PRIO_EN
            last  <= 2'd3;
`endif
        end else if (take && (req != '0)) begin
            state <= GRANT;
            gnt   <= 4'b0001 << win;
            sel   <= win;
            busy  <= 1'b1;
            cnt   <= CNT_W'(HOLD - 1);
`ifndef TRANS4_FIXED_PRIO_EN
            last  <= win;
`endif
        end else if (take) begin
            state <= IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
        end else begin
            cnt   <= cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_trans4_rr_sched.sv
// Directed bench for trans4_rr_sched (default round-robin build), HOLD=4 and HOLD=1 instances.
module tb_trans4_rr_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] gnt, gnt1;
    logic [1:0] sel, sel1;
    logic       busy, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trans4_rr_sched #(.HOLD(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .sel(sel), .busy(busy)
    );

    trans4_rr_sched #(.HOLD(1), .CNT_W(4)) dut_h1 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt1), .sel(sel1), .busy(busy1)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] g, input logic [1:0] s, input logic b);
        check({name, ".gnt"}, gnt, g);
        check({name, ".sel"}, {2'b00, sel}, {2'b00, s});
        check({name, ".busy"}, {3'b000, busy}, {3'b000, b});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 4'b1111;
        rst = 1'b1;
        #1;
        check_out("rst_now", 4'b0000, 2'd0, 1'b0);
        check("rst_now_h1.gnt", gnt1, 4'b0000);
        step();
        check_out("rst_held", 4'b0000, 2'd0, 1'b0);
        step();
        check_out("rst_held2", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0000;
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s, input logic b, input int n);
        vec_t v;
        v.req = r; v.gnt = g; v.sel = s; v.busy = b;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Full contention rotation, 4 cycles per grant, back to channel 0.
        add(4'b1111, 4'b0001, 2'd0, 1'b1, 4);
        add(4'b1111, 4'b0010, 2'd1, 1'b1, 4);
        add(4'b1111, 4'b0100, 2'd2, 1'b1, 4);
        add(4'b1111, 4'b1000, 2'd3, 1'b1, 4);
        add(4'b1111, 4'b0001, 2'd0, 1'b1, 1);
        // Release all: idle, sel holds.
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 2);
        // Sole requester re-granted across two reloads without a gap.
        add(4'b0100, 4'b0100, 2'd2, 1'b1, 9);
        add(4'b0000, 4'b0000, 2'd2, 1'b0, 1);
        // From last=2, channel 3 wins; then early release hands to 0 with no bubble.
        add(4'b1001, 4'b1000, 2'd3, 1'b1, 2);
        add(4'b0001, 4'b0001, 2'd0, 1'b1, 2);
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 1);

        do_reset();
        foreach (vecs[i]) begin
            req = vecs[i].req;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy);
        end

        // Early release: holder 1 drops after two granted cycles, 3 takes over on that edge.
        do_reset();
        req = 4'b1010;
        step();
        check_out("er_g1", 4'b0010, 2'd1, 1'b1);
        step();
        check_out("er_g2", 4'b0010, 2'd1, 1'b1);
        req = 4'b1000;
        step();
        check_out("er_hand", 4'b1000, 2'd3, 1'b1);
        req = 4'b0000;
        step();
        check_out("er_idle", 4'b0000, 2'd3, 1'b0);

        // Asynchronous reset mid-grant, then fresh priority from channel 0.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 10; i++) step();
        check_out("mid_before", 4'b0100, 2'd2, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_out("mid_async", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_out("mid_after", 4'b0001, 2'd0, 1'b1);

        // HOLD=1 instance rotates every cycle under full contention.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            logic [3:0] exp1;
            exp1 = 4'b0001 << (i % 4);
            step();
            check($sformatf("h1_rot%0d.gnt", i), gnt1, exp1);
            check($sformatf("h1_rot%0d.sel", i), {2'b00, sel1}, 4'(i % 4));
            check($sformatf("h1_rot%0d.busy", i), {3'b000, busy1}, 4'd1);
        end
        req = 4'b0000;
        step();
        check("h1_idle.gnt", gnt1, 4'b0000);
        check("h1_idle.busy", {3'b000, busy1}, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
